// File: rtl/timer_irq_ctrl.sv
// Timer interrupt arbiter: picks the highest enabled TIFR flag, runs the
// req/ack handshake with the CPU, then issues the flag-clear and I-clear strobes.
module timer_irq_ctrl #(
    parameter logic [15:0] VEC_BASE = 16'h0008,
    parameter int unsigned VEC_STEP = 2
) (
    input  logic        sysClock,
    input  logic        rst,
    input  logic [7:0]  TIFR_in,
    input  logic [7:0]  TIMSK_in,
    input  logic        global_ie,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [15:0] irq_vector,
    output logic [7:0]  TIFR_clear_data,
    output logic        TIFR_clear_enable,
    output logic        clear_I,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CLEAR = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [15:0] VEC_STEP_W = 16'(VEC_STEP);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        req_q, req_d;
    logic [15:0] vec_q, vec_d;
    logic [7:0]  clr_data_q, clr_data_d;
    logic        clr_en_q, clr_en_d;
    logic        clear_i_q, clear_i_d;

    logic [7:0]  pending;
    logic [2:0]  sel_idx;

    // Vector table runs downwards in priority: idx 7 sits at VEC_BASE.
    function automatic logic [15:0] vec_of(input logic [2:0] idx);
        return VEC_BASE + VEC_STEP_W * (16'd7 - {13'd0, idx});
    endfunction

    assign pending = TIFR_in & TIMSK_in;

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    // Handshake: irq_req stays high with a stable irq_vector until the cycle
    // irq_ack is sampled high; ack wins over a simultaneous withdraw, and an
    // ack seen while irq_req is low is ignored.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        req_d      = 1'b0;
        vec_d      = vec_q;
        clr_data_d = 8'h00;
        clr_en_d   = 1'b0;
        clear_i_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (global_ie && (pending != 8'h00)) begin
                    state_d = REQ;
                    idx_d   = sel_idx;
                    req_d   = 1'b1;
                    vec_d   = vec_of(sel_idx);
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d    = CLEAR;
                    clr_en_d   = 1'b1;
                    clr_data_d = 8'b0000_0001 << idx_q;
                    clear_i_d  = 1'b1;
                end else if (!global_ie || !pending[idx_q]) begin
                    state_d = IDLE;
                end else begin
                    req_d = 1'b1;
                end
            end
            CLEAR: state_d = HOLD;
            HOLD:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysClock) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            req_q      <= 1'b0;
            vec_q      <= 16'h0000;
            clr_data_q <= 8'h00;
            clr_en_q   <= 1'b0;
            clear_i_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            req_q      <= req_d;
            vec_q      <= vec_d;
            clr_data_q <= clr_data_d;
            clr_en_q   <= clr_en_d;
            clear_i_q  <= clear_i_d;
        end
    end

    assign irq_req           = req_q;
    assign irq_vector        = vec_q;
    assign TIFR_clear_data   = clr_data_q;
    assign TIFR_clear_enable = clr_en_q;
    assign clear_I           = clear_i_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl: arbitration, handshake, withdraw and reset cases.
module tb_timer_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  tifr;
    logic [7:0]  timsk;
    logic        gie;
    logic        ack;
    logic        irq_req;
    logic [15:0] irq_vector;
    logic [7:0]  clr_data;
    logic        clr_en;
    logic        clear_i;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    timer_irq_ctrl dut (
        .sysClock          (clk),
        .rst               (rst),
        .TIFR_in           (tifr),
        .TIMSK_in          (timsk),
        .global_ie         (gie),
        .irq_ack           (ack),
        .irq_req           (irq_req),
        .irq_vector        (irq_vector),
        .TIFR_clear_data   (clr_data),
        .TIFR_clear_enable (clr_en),
        .clear_I           (clear_i),
        .busy              (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one edge, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_req"}, 32'(irq_req), 32'd0);
        check_val({tag, "_clr_en"}, 32'(clr_en), 32'd0);
        check_val({tag, "_clear_i"}, 32'(clear_i), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // DUT is expected to be in REQ: compare against the head of the queue
    task automatic expect_req(input string tag);
        logic [15:0] exp_vec;
        check_val({tag, "_req"}, 32'(irq_req), 32'd1);
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            exp_vec = exp_q.pop_front();
            check_val({tag, "_vec"}, 32'(irq_vector), 32'(exp_vec));
        end
    endtask

    // ack the current request, model the timer clearing its flag, walk CLEAR/HOLD
    task automatic do_ack(input string tag, input logic [7:0] exp_data);
        ack = 1'b1;
        step();
        check_val({tag, "_clr_en"}, 32'(clr_en), 32'd1);
        check_val({tag, "_clr_data"}, 32'(clr_data), 32'(exp_data));
        check_val({tag, "_clear_i"}, 32'(clear_i), 32'd1);
        check_val({tag, "_clr_req"}, 32'(irq_req), 32'd0);
        ack  = 1'b0;
        tifr = tifr & ~exp_data;
        step();
        check_val({tag, "_hold_clr_en"}, 32'(clr_en), 32'd0);
        check_val({tag, "_hold_clear_i"}, 32'(clear_i), 32'd0);
        check_val({tag, "_hold_busy"}, 32'(busy), 32'd1);
        step();
        check_idle_outputs({tag, "_idle"});
    endtask

    initial begin
        rst   = 1'b1;
        tifr  = 8'h00;
        timsk = 8'h00;
        gie   = 1'b0;
        ack   = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        check_val("reset_vec", 32'(irq_vector), 32'h0);
        check_val("reset_clr_data", 32'(clr_data), 32'h0);
        rst = 1'b0;

        // lowest priority flag alone
        timsk = 8'h01;
        tifr  = 8'h01;
        gie   = 1'b1;
        exp_q.push_back(16'h0016);
        step();
        expect_req("t0ov");
        do_ack("t0ov", 8'h01);

        // mixed flags: idx 4 first, then idx 1
        timsk = 8'hFF;
        tifr  = 8'h13;
        exp_q.push_back(16'h000E);
        step();
        expect_req("mix4");
        do_ack("mix4", 8'h10);
        exp_q.push_back(16'h0014);
        step();
        expect_req("mix1");

        // higher-priority flag arriving in REQ must not re-arbitrate
        tifr = 8'h83;
        exp_q.push_back(16'h0014);
        step();
        expect_req("noarb");
        do_ack("noarb", 8'h02);
        exp_q.push_back(16'h0008);
        step();
        expect_req("idx7");
        do_ack("idx7", 8'h80);
        exp_q.push_back(16'h0016);
        step();
        expect_req("idx0");
        do_ack("idx0", 8'h01);

        // masked flag never requests
        tifr  = 8'h04;
        timsk = 8'h00;
        step();
        step();
        check_idle_outputs("masked");
        timsk = 8'h04;
        exp_q.push_back(16'h0012);
        step();
        expect_req("unmask");

        // withdraw on global_ie drop
        gie = 1'b0;
        step();
        check_idle_outputs("wd_gie");
        step();
        check_idle_outputs("wd_gie_stay");
        gie = 1'b1;
        exp_q.push_back(16'h0012);
        step();
        expect_req("rereq");

        // withdraw on flag clear
        tifr = 8'h00;
        step();
        check_idle_outputs("wd_flag");

        // ack and withdraw together: ack wins
        tifr = 8'h04;
        exp_q.push_back(16'h0012);
        step();
        expect_req("ackwd");
        gie = 1'b0;
        do_ack("ackwd", 8'h04);
        gie = 1'b1;

        // reset during CLEAR drops everything
        timsk = 8'hFF;
        tifr  = 8'h20;
        exp_q.push_back(16'h000C);
        step();
        expect_req("prerst");
        ack = 1'b1;
        step();
        check_val("prerst_clr_en", 32'(clr_en), 32'd1);
        rst = 1'b1;
        ack = 1'b0;
        step();
        check_idle_outputs("rst_clear");
        check_val("rst_clear_vec", 32'(irq_vector), 32'h0);
        check_val("rst_clear_data", 32'(clr_data), 32'h0);

        // ack held high in IDLE is ignored; a normal single request follows
        rst = 1'b0;
        ack = 1'b1;
        exp_q.push_back(16'h000C);
        step();
        expect_req("ackidle");
        check_val("ackidle_clr_en", 32'(clr_en), 32'd0);
        ack = 1'b0;
        exp_q.push_back(16'h000C);
        step();
        expect_req("ackidle_hold");
        do_ack("ackidle", 8'h20);
        step();
        check_idle_outputs("final");

        check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
